seq_div4_ctrl: RTL and testbench

- Sequential 4-bit unsigned restoring divider controller.
- Drives one instance of the team's 4-bit adder/subtractor (bit_4_addsub) in subtract mode for one trial subtraction per clock.
- Sequences four iterations through the FSM and returns quotient/remainder with a start/busy/done handshake.
- Sits beside the ALU datapath as the multi-cycle divide unit.

---
 rtl/seq_div4_ctrl.sv | 168 ++++++++++++++++
 tb/tb_seq_div4_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div4_ctrl.sv
// rtl/seq_div4_ctrl.sv - sequential 4-bit unsigned restoring divider with start/busy/done handshake

// Shared 4-bit ripple adder/subtractor: m=1 computes a-b as a+~b+1.
module bit_4_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       m,
    output logic [3:0] s,
    output logic       c,
    output logic       v
);

    logic [4:0] carry;
    logic [3:0] b_x;

    // Ripple-carry chain; carry out is "no borrow" when subtracting
    always_comb begin
        b_x      = b ^ {4{m}};
        carry    = '0;
        carry[0] = m;
        s        = '0;
        for (int i = 0; i < 4; i++) begin
            s[i]       = a[i] ^ b_x[i] ^ carry[i];
            carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
        end
        c = carry[4];
        v = carry[4] ^ carry[3];
    end

endmodule

module seq_div4_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero,
    output logic [3:0] quotient,
    output logic [3:0] remainder
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [3:0] r_q, r_d;
    logic [3:0] q_q, q_d;
    logic [3:0] d_q, d_d;
    logic [3:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;
    logic       dbz_q, dbz_d;

    logic [3:0] shifted;
    logic       shifted_msb;
    logic [3:0] sub_s;
    logic       sub_c;
    logic       sub_v_unused;
    logic       qbit;
    logic [3:0] r_next;
    logic [3:0] q_next;

    // One trial subtraction per clock: shifted partial remainder minus divisor
    bit_4_addsub u_addsub (
        .a (shifted),
        .b (d_q),
        .m (1'b1),
        .s (sub_s),
        .c (sub_c),
        .v (sub_v_unused)
    );

    // Restoring step: a set R[3] means the shifted value is >= 16 > divisor,
    // so the subtraction always succeeds even though the 4-bit adder wraps.
    always_comb begin
        shifted     = {r_q[2:0], q_q[3]};
        shifted_msb = r_q[3];
        qbit        = shifted_msb | sub_c;
        r_next      = qbit ? sub_s : shifted;
        q_next      = {q_q[2:0], qbit};
    end

    // Next-state and register updates for the IDLE/CALC/DONE sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (divisor == 4'd0) begin
                        quotient_d  = 4'hF;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        r_d     = 4'd0;
                        q_d     = dividend;
                        d_d     = divisor;
                        cnt_d   = 2'd0;
                        dbz_d   = 1'b0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                r_d   = r_next;
                q_d   = q_next;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    quotient_d  = q_next;
                    remainder_d = r_next;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            r_q         <= 4'd0;
            q_q         <= 4'd0;
            d_q         <= 4'd0;
            quotient_q  <= 4'd0;
            remainder_q <= 4'd0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // Handshake outputs decode directly from state so they cannot overlap
    always_comb begin
        busy        = (state_q == S_CALC);
        done        = (state_q == S_DONE);
        div_by_zero = dbz_q;
        quotient    = quotient_q;
        remainder   = remainder_q;
    end

endmodule

// File: tb/tb_seq_div4_ctrl.sv
// tb/tb_seq_div4_ctrl.sv - self-checking bench for seq_div4_ctrl

module tb_seq_div4_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic       div_by_zero;
    logic [3:0] quotient;
    logic [3:0] remainder;

    int checks = 0;
    int errors = 0;

    seq_div4_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_q;
        logic [3:0] exp_r;
        logic       exp_dbz;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // busy and done must never overlap
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap actual=1 required=0");
            end
        end
    end

    function automatic logic [8:0] model(input logic [3:0] a, input logic [3:0] b);
        int q, r;
        if (b == 0) return {1'b1, 4'hF, a};
        q = a / b;
        r = a % b;
        return {1'b0, q[3:0], r[3:0]};
    endfunction

    // Pulse start with (a,b), then switch the operand inputs to (a2,b2).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] a2, input logic [3:0] b2,
                          output int done_cyc, output int busy_cnt);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = a2;
        divisor  = b2;
        done_cyc = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done) begin
                done_cyc = k;
                break;
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] a2, input logic [3:0] b2,
                            input logic [3:0] eq, input logic [3:0] er, input logic edbz);
        int dc, bc;
        run_op(a, b, a2, b2, dc, bc);
        chk({tag, "_done_cycle"}, 8'(dc), (b == 0) ? 8'd1 : 8'd5);
        chk({tag, "_busy_cycles"}, 8'(bc), (b == 0) ? 8'd0 : 8'd4);
        chk({tag, "_q"}, {4'd0, quotient}, {4'd0, eq});
        chk({tag, "_r"}, {4'd0, remainder}, {4'd0, er});
        chk({tag, "_dbz"}, {7'd0, div_by_zero}, {7'd0, edbz});
        @(negedge clk);
        chk({tag, "_done_single"}, {7'd0, done}, 8'd0);
        chk({tag, "_q_held"}, {4'd0, quotient}, {4'd0, eq});
    endtask

    vec_t vecs[10];

    initial begin
        logic [8:0] m;
        logic [3:0] ra, rb, ra2, rb2;

        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0};
        vecs[2] = '{4'd2,  4'd9,  4'd0,  4'd2, 1'b0};
        vecs[3] = '{4'd15, 4'd14, 4'd1,  4'd1, 1'b0};
        vecs[4] = '{4'd14, 4'd8,  4'd1,  4'd6, 1'b0};
        vecs[5] = '{4'd7,  4'd0,  4'hF,  4'd7, 1'b1};
        vecs[6] = '{4'd6,  4'd2,  4'd3,  4'd0, 1'b0};
        vecs[7] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0};
        vecs[8] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0};
        vecs[9] = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 4'd0;
        divisor  = 4'd0;
        @(negedge clk);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_dbz", {7'd0, div_by_zero}, 8'd0);
        chk("rst_q", {4'd0, quotient}, 8'd0);
        chk("rst_r", {4'd0, remainder}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].b,
                     vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz);
        end

        // start re-pulsed during CALC and DONE is ignored; operands changed after accept
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk);
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("repulse_busy_c4", {7'd0, busy}, 8'd1);
        @(negedge clk);
        chk("repulse_done_c5", {7'd0, done}, 8'd1);
        chk("repulse_q", {4'd0, quotient}, 8'd4);
        chk("repulse_r", {4'd0, remainder}, 8'd1);
        start = 1'b1; dividend = 4'd2; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0;
        chk("repulse_idle_busy", {7'd0, busy}, 8'd0);
        chk("repulse_idle_done", {7'd0, done}, 8'd0);
        @(negedge clk);
        chk("repulse_not_accepted", {7'd0, busy}, 8'd0);
        chk("repulse_q_held", {4'd0, quotient}, 8'd4);

        // start held high: second operation accepted on the IDLE cycle after DONE
        @(negedge clk);
        start = 1'b1; dividend = 4'd6; divisor = 4'd2;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            chk($sformatf("held_busy_c%0d", k), {7'd0, busy},
                ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)) ? 8'd1 : 8'd0);
            chk($sformatf("held_done_c%0d", k), {7'd0, done}, (k == 5 || k == 11) ? 8'd1 : 8'd0);
            if (k == 3) begin dividend = 4'd9; divisor = 4'd4; end
            if (k == 5) begin
                chk("held_q1", {4'd0, quotient}, 8'd3);
                chk("held_r1", {4'd0, remainder}, 8'd0);
            end
            if (k == 7) start = 1'b0;
            if (k == 11) begin
                chk("held_q2", {4'd0, quotient}, 8'd2);
                chk("held_r2", {4'd0, remainder}, 8'd1);
            end
        end
        @(negedge clk);

        // asynchronous reset in the middle of CALC
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {7'd0, busy}, 8'd0);
        chk("arst_done", {7'd0, done}, 8'd0);
        chk("arst_q", {4'd0, quotient}, 8'd0);
        chk("arst_r", {4'd0, remainder}, 8'd0);
        chk("arst_dbz", {7'd0, div_by_zero}, 8'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("arst_no_done", {7'd0, done}, 8'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_idle_busy", {7'd0, busy}, 8'd0);
        chk("arst_idle_done", {7'd0, done}, 8'd0);
        check_op("post_rst", 4'd9, 4'd4, 4'd9, 4'd4, 4'd2, 4'd1, 1'b0);

        // exhaustive operand sweep against the arithmetic model
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                m = model(a[3:0], b[3:0]);
                check_op($sformatf("sweep_%0d_%0d", a, b), a[3:0], b[3:0], a[3:0], b[3:0],
                         m[7:4], m[3:0], m[8]);
            end
        end

        // randomized operations with operand inputs scrambled after accept
        for (int i = 0; i < 60; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = 4'($urandom_range(0, 15));
            ra2 = 4'($urandom_range(0, 15));
            rb2 = 4'($urandom_range(0, 15));
            m   = model(ra, rb);
            check_op($sformatf("rand%0d_%0d_%0d", i, ra, rb), ra, rb, ra2, rb2,
                     m[7:4], m[3:0], m[8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
